imem_dmem_arbiter: RTL and testbench

- Arbitrates one single-port synchronous memory between the CPU's instruction-fetch port and its load/store port.
- Lets the flow CPU run from a unified instruction/data RAM in the SoC top.
- Issues the memory cycle and waits MEM_LAT cycles for read data.
- Returns data with a one-cycle ready pulse and drives a pipeline stall request.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/imem_dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one synchronous RAM between fetch and load/store.
// Data side wins ties; a starvation counter forces periodic fetch progress.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              stall_req_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] LAT_M1   = 2'(MEM_LAT - 1);
  localparam logic [2:0] STARVE_L = 3'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        starve_q, starve_d;
  logic              g_q, g_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              starved;
  logic              d_win;

  assign starved = if_req_i && (starve_q == STARVE_L);
  assign d_win   = dm_req_i && !starved;

  // Arbitrate in IDLE, count out the RAM latency, capture, pulse ready.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    g_d        = g_q;
    ce_d       = ce_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!if_req_i) starve_d = 3'd0;
        if (d_win) begin
          state_d = S_BUSY_D;
          g_d     = 1'b1;
          ce_d    = 1'b1;
          we_d    = dm_we_i;
          sel_d   = dm_we_i ? dm_sel_i : 4'hF;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          cnt_d   = LAT_M1;
          // d_win with a waiting fetch implies starve_q < limit
          if (if_req_i) starve_d = starve_q + 3'd1;
        end else if (if_req_i) begin
          state_d  = S_BUSY_I;
          g_d      = 1'b0;
          ce_d     = 1'b1;
          we_d     = 1'b0;
          sel_d    = 4'hF;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          cnt_d    = LAT_M1;
          starve_d = 3'd0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        // one write strobe per store, however long the latency
        we_d = 1'b0;
        if (cnt_q == 2'd0) begin
          ce_d    = 1'b0;
          state_d = S_DONE;
          if (g_q) dm_rdata_d = ram_rdata_i;
          else     if_rdata_d = ram_rdata_i;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered RAM-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      starve_q   <= 3'd0;
      g_q        <= 1'b0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      g_q        <= g_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ready_o  = (state_q == S_DONE) && !g_q;
  assign dm_ready_o  = (state_q == S_DONE) && g_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign ram_ce_o    = ce_q;
  assign ram_we_o    = we_q;
  assign ram_sel_o   = sel_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

  assign stall_req_o = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed bench, one DUT at MEM_LAT=1, one at MEM_LAT=3.
// Each RAM model returns junk until the last latency cycle of an access.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_sel;

  logic [31:0] if_rdata1, dm_rdata1, addr1, wdata1, rd1;
  logic        if_ready1, dm_ready1, stall1, ce1, we1;
  logic [3:0]  sel1;
  logic [31:0] if_rdata3, dm_rdata3, addr3, wdata3, rd3;
  logic        if_ready3, dm_ready3, stall3, ce3, we3;
  logic [3:0]  sel3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [1:0]  cc1 = 2'd0;
  logic [1:0]  cc3 = 2'd0;
  int          we_cnt1 = 0;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata1), .if_ready_o(if_ready1),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_sel_i(dm_sel),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata1), .dm_ready_o(dm_ready1),
    .stall_req_o(stall1),
    .ram_ce_o(ce1), .ram_we_o(we1), .ram_sel_o(sel1),
    .ram_addr_o(addr1), .ram_wdata_o(wdata1), .ram_rdata_i(rd1)
  );

  imem_dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata3), .if_ready_o(if_ready3),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_sel_i(dm_sel),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata3), .dm_ready_o(dm_ready3),
    .stall_req_o(stall3),
    .ram_ce_o(ce3), .ram_we_o(we3), .ram_sel_o(sel3),
    .ram_addr_o(addr3), .ram_wdata_o(wdata3), .ram_rdata_i(rd3)
  );

  // RAM models: byte-enabled writes, data valid only on the last cycle
  always @(posedge clk) begin
    cc1 <= ce1 ? cc1 + 2'd1 : 2'd0;
    cc3 <= ce3 ? cc3 + 2'd1 : 2'd0;
    if (pl_en) begin
      mem1[pl_idx] <= pl_val;
      mem3[pl_idx] <= pl_val;
    end else begin
      if (ce1 && we1) begin
        we_cnt1 <= we_cnt1 + 1;
        for (int b = 0; b < 4; b++)
          if (sel1[b]) mem1[addr1[9:2]][8*b +: 8] <= wdata1[8*b +: 8];
      end
      if (ce3 && we3)
        for (int b = 0; b < 4; b++)
          if (sel3[b]) mem3[addr3[9:2]][8*b +: 8] <= wdata3[8*b +: 8];
    end
  end

  assign rd1 = (ce1 && cc1 == 2'd0) ? mem1[addr1[9:2]] : 32'hBAD0_BAD0;
  assign rd3 = (ce3 && cc3 == 2'd2) ? mem3[addr3[9:2]] : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_sel = 4'h0;
    dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = idx; pl_val = v;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    idle_inputs;
    preload(8'd4, 32'h3401_0020);
    preload(8'd64, 32'hDEAD_BEEF);
    preload(8'd128, 32'hAAAA_AAAA);
    tick;
    total_cnt++;
    if ({ce1, we1, sel1, addr1, wdata1} !== '0) begin
      $display("FAIL reset_ram1: got %h want 0", {ce1, we1, sel1, addr1, wdata1});
    end else pass_cnt++;
    total_cnt++;
    if ({if_ready1, dm_ready1, if_rdata1, dm_rdata1} !== '0) begin
      $display("FAIL reset_cpu1: got %h want 0",
               {if_ready1, dm_ready1, if_rdata1, dm_rdata1});
    end else pass_cnt++;
    total_cnt++;
    if ({ce3, if_ready3, dm_ready3, stall1} !== 4'b0) begin
      $display("FAIL reset_misc: got %b want 0000", {ce3, if_ready3, dm_ready3, stall1});
    end else pass_cnt++;
    dm_req = 1'b1;
    #1;
    total_cnt++;
    if ({stall1, stall3} !== 2'b11) begin
      $display("FAIL reset_stall: got %b want 11", {stall1, stall3});
    end else pass_cnt++;
    dm_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    do_reset;
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    total_cnt++;
    if (stall1 !== 1'b1) $display("FAIL fetch_stall_t0: got %b want 1", stall1);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({ce1, we1, addr1, stall1} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
      $display("FAIL fetch_t1: got ce=%b we=%b addr=%h stall=%b want 1 0 10 1",
               ce1, we1, addr1, stall1);
    end else pass_cnt++;
    tick;
    total_cnt++;
    if ({ce1, if_ready1, dm_ready1, stall1} !== 4'b0100 ||
        if_rdata1 !== 32'h3401_0020) begin
      $display("FAIL fetch_t2: got ce=%b rdy=%b drdy=%b stall=%b data=%h want 0 1 0 0 34010020",
               ce1, if_ready1, dm_ready1, stall1, if_rdata1);
    end else pass_cnt++;
    if_req = 1'b0;
    tick;
    total_cnt++;
    if (if_ready1 !== 1'b0 || if_rdata1 !== 32'h3401_0020) begin
      $display("FAIL fetch_hold: got rdy=%b data=%h want 0 34010020", if_ready1, if_rdata1);
    end else pass_cnt++;
  endtask

  task automatic test_load_fetch;
    do_reset;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h10;
    tick;
    total_cnt++;
    if (ce1 !== 1'b1 || addr1 !== 32'h100) begin
      $display("FAIL lf_dgrant: got ce=%b addr=%h want 1 100", ce1, addr1);
    end else pass_cnt++;
    tick;
    total_cnt++;
    if ({dm_ready1, if_ready1} !== 2'b10 || dm_rdata1 !== 32'hDEAD_BEEF) begin
      $display("FAIL lf_dready: got rdy=%b%b data=%h want 10 deadbeef",
               dm_ready1, if_ready1, dm_rdata1);
    end else pass_cnt++;
    dm_req = 1'b0;
    tick;
    total_cnt++;
    if ({ce1, dm_ready1, if_ready1} !== 3'b000) begin
      $display("FAIL lf_t3: got %b want 000", {ce1, dm_ready1, if_ready1});
    end else pass_cnt++;
    tick;
    total_cnt++;
    if (ce1 !== 1'b1 || addr1 !== 32'h10) begin
      $display("FAIL lf_igrant: got ce=%b addr=%h want 1 10", ce1, addr1);
    end else pass_cnt++;
    tick;
    total_cnt++;
    if (if_ready1 !== 1'b1 || if_rdata1 !== 32'h3401_0020) begin
      $display("FAIL lf_iready: got rdy=%b data=%h want 1 34010020", if_ready1, if_rdata1);
    end else pass_cnt++;
    if_req = 1'b0;
  endtask

  task automatic test_store_load;
    int w0;
    do_reset;
    w0 = we_cnt1;
    dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011;
    dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
    tick;
    total_cnt++;
    if ({we1, sel1, addr1, wdata1} !== {1'b1, 4'b0011, 32'h200, 32'h1234_5678}) begin
      $display("FAIL st_issue: got we=%b sel=%b addr=%h wd=%h want 1 0011 200 12345678",
               we1, sel1, addr1, wdata1);
    end else pass_cnt++;
    tick;
    total_cnt++;
    if (dm_ready1 !== 1'b1 || we1 !== 1'b0) begin
      $display("FAIL st_ready: got rdy=%b we=%b want 1 0", dm_ready1, we1);
    end else pass_cnt++;
    dm_req = 1'b0; dm_we = 1'b0;
    tick;
    dm_req = 1'b1;
    tick;
    total_cnt++;
    if ({we1, sel1} !== {1'b0, 4'hF}) begin
      $display("FAIL ld_issue: got we=%b sel=%b want 0 1111", we1, sel1);
    end else pass_cnt++;
    tick;
    total_cnt++;
    if (dm_ready1 !== 1'b1 || dm_rdata1 !== 32'hAAAA_5678) begin
      $display("FAIL ld_after_st: got rdy=%b data=%h want 1 aaaa5678", dm_ready1, dm_rdata1);
    end else pass_cnt++;
    dm_req = 1'b0;
    total_cnt++;
    if (we_cnt1 - w0 !== 1) $display("FAIL st_we_cycles: got %0d want 1", we_cnt1 - w0);
    else pass_cnt++;
  endtask

  task automatic test_starvation;
    int n;
    logic is_d;
    do_reset;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      is_d = !(k == 4 || k == 9);
      n = 0;
      do begin
        tick;
        n++;
      end while (!(if_ready1 || dm_ready1) && n < 8);
      total_cnt++;
      if ({dm_ready1, if_ready1} !== {is_d, !is_d}) begin
        $display("FAIL starve_grant%0d: got d/i=%b%b want %b%b",
                 k, dm_ready1, if_ready1, is_d, !is_d);
      end else pass_cnt++;
    end
    idle_inputs;
  endtask

  task automatic test_lat3_load;
    int ce_n, rdy_at;
    logic [31:0] rd;
    do_reset;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    ce_n = 0; rdy_at = 0; rd = '0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (ce3) ce_n++;
      if (dm_ready3 && rdy_at == 0) begin
        rdy_at = k;
        rd = dm_rdata3;
        dm_req = 1'b0;
      end
    end
    total_cnt++;
    if (ce_n !== 3) $display("FAIL lat3_ce_cycles: got %0d want 3", ce_n);
    else pass_cnt++;
    total_cnt++;
    if (rdy_at !== 4 || rd !== 32'hDEAD_BEEF) begin
      $display("FAIL lat3_ready: got at=%0d data=%h want 4 deadbeef", rdy_at, rd);
    end else pass_cnt++;
    idle_inputs;
  endtask

  task automatic test_reset_mid;
    int first, pulses;
    logic [31:0] rd;
    do_reset;
    if_req = 1'b1; if_addr = 32'h10;
    tick;
    tick;
    total_cnt++;
    if (ce3 !== 1'b1) $display("FAIL mid_busy2: got ce=%b want 1", ce3);
    else pass_cnt++;
    rst = 1'b1;
    tick;
    total_cnt++;
    if ({ce3, we3, sel3, addr3, wdata3, if_ready3, if_rdata3} !== '0 || stall3 !== 1'b1) begin
      $display("FAIL mid_reset: got ce=%b addr=%h rdy=%b data=%h stall=%b want 0 0 0 0 1",
               ce3, addr3, if_ready3, if_rdata3, stall3);
    end else pass_cnt++;
    rst = 1'b0;
    first = 0; pulses = 0; rd = '0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (if_ready3) begin
        pulses++;
        if (first == 0) begin
          first = k;
          rd = if_rdata3;
          if_req = 1'b0;
        end
      end
    end
    total_cnt++;
    if (first !== 4 || pulses !== 1 || rd !== 32'h3401_0020) begin
      $display("FAIL mid_regrant: got at=%0d pulses=%0d data=%h want 4 1 34010020",
               first, pulses, rd);
    end else pass_cnt++;
    idle_inputs;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load_fetch;
    test_store_load;
    test_starvation;
    test_lat3_load;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
